// File: rtl/grid_pkg.sv
// grid_pkg: direction codes and position helpers shared by the grid movement blocks
package grid_pkg;
    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    function automatic logic [2:0] opposite(input logic [2:0] d);
        return d == DIR_UP    ? DIR_DOWN  :
               d == DIR_DOWN  ? DIR_UP    :
               d == DIR_LEFT  ? DIR_RIGHT :
               d == DIR_RIGHT ? DIR_LEFT  : DIR_STOP;
    endfunction

    // One pixel along the axis selected by is_y; y grows downwards, so UP decrements.
    function automatic logic [31:0] step_pos(input logic [31:0] pos, input logic [2:0] d, input logic is_y);
        logic [2:0] dec;
        logic [2:0] inc;
        dec = is_y ? DIR_UP : DIR_LEFT;
        inc = is_y ? DIR_DOWN : DIR_RIGHT;
        return d == dec ? pos - 32'd1 : d == inc ? pos + 32'd1 : pos;
    endfunction
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: movement step strobe, one tick per TICK_DIV clocks (half that when boosted)
module move_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic boost,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LIM_NORM = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LIM_FAST = CW'(TICK_DIV / 2 - 1);

    logic [CW-1:0] cnt;

    // >= rather than == so a boost switch with cnt already past the short limit ticks at once
    assign tick = en && cnt >= (boost ? LIM_FAST : LIM_NORM);

    // Counter: frozen while disabled, restarted on tick or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/grid_mover.sv
// grid_mover: tile-grid sprite movement with buffered turns, external wall probes and bump events
module grid_mover import grid_pkg::*; #(
    parameter int COORD_W   = 10,
    parameter int TILE_LOG2 = 5,
    parameter int SPAWN_X   = 160,
    parameter int SPAWN_Y   = 224,
    parameter int TICK_DIV  = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               respawn,
    input  logic               boost,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic               btn_l,
    input  logic               btn_r,
    output logic [COORD_W-1:0] probe_req_x,
    output logic [COORD_W-1:0] probe_req_y,
    input  logic               wall_req,
    output logic [COORD_W-1:0] probe_cur_x,
    output logic [COORD_W-1:0] probe_cur_y,
    input  logic               wall_cur,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic [2:0]         heading,
    output logic               step_pulse,
    output logic               bump
);
    localparam logic [COORD_W-1:0] SX = COORD_W'(SPAWN_X);
    localparam logic [COORD_W-1:0] SY = COORD_W'(SPAWN_Y);

    logic [2:0]         req_dir, cur_dir, nxt_dir, btn_dir;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               nxt_bump, tick, aligned;

    move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .boost (boost),
        .clear (respawn),
        .tick  (tick)
    );

    assign probe_req_x = COORD_W'(step_pos(32'(player_x), req_dir, 1'b0));
    assign probe_req_y = COORD_W'(step_pos(32'(player_y), req_dir, 1'b1));
    assign probe_cur_x = COORD_W'(step_pos(32'(player_x), cur_dir, 1'b0));
    assign probe_cur_y = COORD_W'(step_pos(32'(player_y), cur_dir, 1'b1));
    assign aligned     = ~|player_x[TILE_LOG2-1:0] && ~|player_y[TILE_LOG2-1:0];
    assign heading     = cur_dir;
    assign btn_dir     = btn_u ? DIR_UP : btn_d ? DIR_DOWN : btn_l ? DIR_LEFT : btn_r ? DIR_RIGHT : req_dir;

    // Tick decision: turns only at tile alignment, except an immediate reversal mid-tile
    always_comb begin
        nxt_x    = player_x;
        nxt_y    = player_y;
        nxt_dir  = cur_dir;
        nxt_bump = 1'b0;
        if (tick) begin
            if (aligned && req_dir != DIR_STOP && !wall_req) begin
                nxt_dir = req_dir;
                nxt_x   = probe_req_x;
                nxt_y   = probe_req_y;
            end else if (aligned && cur_dir != DIR_STOP && !wall_cur) begin
                nxt_x = probe_cur_x;
                nxt_y = probe_cur_y;
            end else if (aligned) begin
                nxt_dir  = DIR_STOP;
                nxt_bump = cur_dir != DIR_STOP;
            end else if (req_dir == opposite(cur_dir) && !wall_req) begin
                nxt_dir = req_dir;
                nxt_x   = probe_req_x;
                nxt_y   = probe_req_y;
            end else begin
                nxt_x = probe_cur_x;
                nxt_y = probe_cur_y;
            end
        end
    end

    // State register: respawn overrides everything; the request register samples buttons even while paused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_x   <= SX;
            player_y   <= SY;
            cur_dir    <= DIR_STOP;
            req_dir    <= DIR_STOP;
            step_pulse <= 1'b0;
            bump       <= 1'b0;
        end else if (respawn) begin
            player_x   <= SX;
            player_y   <= SY;
            cur_dir    <= DIR_STOP;
            req_dir    <= DIR_STOP;
            step_pulse <= 1'b0;
            bump       <= 1'b0;
        end else begin
            player_x   <= nxt_x;
            player_y   <= nxt_y;
            cur_dir    <= nxt_dir;
            req_dir    <= btn_dir;
            step_pulse <= nxt_x != player_x || nxt_y != player_y;
            bump       <= nxt_bump;
        end
    end
endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: randomized scoreboard bench for grid_mover against a pixel-level maze model
module tb_grid_mover;
    localparam int TD = 4;

    logic       clk = 0, rst_n = 0, en = 0, respawn = 0, boost = 0;
    logic       btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0;
    logic [9:0] probe_req_x, probe_req_y, probe_cur_x, probe_cur_y, player_x, player_y;
    logic       wall_req, wall_cur, step_pulse, bump;
    logic [2:0] heading;

    typedef struct {int x; int y; int h; bit b;} ev_t;
    ev_t q[$];

    int  total = 0, bad = 0, cyc = 0, n_bump = 0, n_step = 0;
    int  m_x, m_y, m_cur, m_req, m_cnt;
    bit  force_chk = 0;
    bit  hblk[8][8];
    bit  vblk[8][8];

    always #5 clk = ~clk;

    // Maze: walkable pixels lie on grid lines x%4==0 or y%4==0 inside 4..28; segments may be blocked.
    function automatic bit is_wall(int x, int y);
        if (x < 4 || x > 28 || y < 4 || y > 28) return 1;
        if (x % 4 != 0 && y % 4 != 0) return 1;
        if (x % 4 != 0) return hblk[x / 4][y / 4];
        if (y % 4 != 0) return vblk[x / 4][y / 4];
        return 0;
    endfunction

    assign wall_req = is_wall(int'(probe_req_x), int'(probe_req_y));
    assign wall_cur = is_wall(int'(probe_cur_x), int'(probe_cur_y));

    grid_mover #(.COORD_W(10), .TILE_LOG2(2), .SPAWN_X(8), .SPAWN_Y(8), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .respawn(respawn), .boost(boost),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .probe_req_x(probe_req_x), .probe_req_y(probe_req_y), .wall_req(wall_req),
        .probe_cur_x(probe_cur_x), .probe_cur_y(probe_cur_y), .wall_cur(wall_cur),
        .player_x(player_x), .player_y(player_y), .heading(heading),
        .step_pulse(step_pulse), .bump(bump)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mv(int p, int d, int dec, int inc);
        return (d == dec ? p - 1 : d == inc ? p + 1 : p) & 1023;
    endfunction

    task automatic model_reset();
        m_x = 8; m_y = 8; m_cur = 0; m_req = 0; m_cnt = 0;
    endtask

    // Reference: what the sprite does on the coming edge, judged by plain maze rules
    task automatic model_update(input bit [3:0] bt, input bit bst, input bit e, input bit rs);
        int opp[5] = '{0, 2, 1, 4, 3};
        int nx, ny, nc, rx, ry, cx, cy;
        bit b, al;
        ev_t ev;
        if (rs) begin
            model_reset();
            return;
        end
        nx = m_x; ny = m_y; nc = m_cur; b = 0;
        if (e && m_cnt + 1 >= (bst ? TD / 2 : TD)) begin
            m_cnt = 0;
            al = (m_x % 4 == 0) && (m_y % 4 == 0);
            rx = mv(m_x, m_req, 3, 4); ry = mv(m_y, m_req, 1, 2);
            cx = mv(m_x, m_cur, 3, 4); cy = mv(m_y, m_cur, 1, 2);
            if (al && m_req != 0 && !is_wall(rx, ry)) begin
                nc = m_req; nx = rx; ny = ry;
            end else if (al && m_cur != 0 && !is_wall(cx, cy)) begin
                nx = cx; ny = cy;
            end else if (al) begin
                b = m_cur != 0; nc = 0;
            end else if (m_req == opp[m_cur] && !is_wall(rx, ry)) begin
                nc = m_req; nx = rx; ny = ry;
            end else begin
                nx = cx; ny = cy;
            end
        end else if (e) begin
            m_cnt++;
        end
        if (nx != m_x || ny != m_y || b) begin
            ev.x = nx; ev.y = ny; ev.h = nc; ev.b = b;
            q.push_back(ev);
        end
        m_x = nx; m_y = ny; m_cur = nc;
        m_req = bt[3] ? 1 : bt[2] ? 2 : bt[1] ? 3 : bt[0] ? 4 : m_req;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_x"}, int'(player_x), m_x);
        chk({tag, "_y"}, int'(player_y), m_y);
        chk({tag, "_heading"}, int'(heading), m_cur);
    endtask

    task automatic step_cycle(input bit [3:0] bt, input bit bst, input bit e, input bit rs);
        @(posedge clk);
        #1;
        cyc++;
        if (force_chk || cyc % 16 == 0) begin
            chk_state("state");
            force_chk = 0;
        end
        {btn_u, btn_d, btn_l, btn_r} = bt;
        boost = bst; en = e; respawn = rs;
        model_update(bt, bst, e, rs);
    endtask

    task automatic run(input int n, input bit [3:0] bt, input bit bst, input bit e);
        for (int i = 0; i < n; i++) step_cycle(bt, bst, e, 0);
    endtask

    // Monitor: every pulse the DUT presents must match the oldest predicted event
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (rst_n && (step_pulse || bump)) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, step_pulse, bump}, 0);
                end else begin
                    ev = q.pop_front();
                    chk("ev_bump", int'(bump), int'(ev.b));
                    chk("ev_step", int'(step_pulse), int'(!ev.b));
                    chk("ev_x", int'(player_x), ev.x);
                    chk("ev_y", int'(player_y), ev.y);
                    chk("ev_heading", int'(heading), ev.h);
                    if (bump) n_bump++; else n_step++;
                end
            end
        end
    end

    initial begin
        bit [3:0] bt;
        bit       bst;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                hblk[i][j] = $urandom_range(3) == 0;
                vblk[i][j] = $urandom_range(3) == 0;
            end
        hblk[2][2] = 0;
        hblk[3][2] = 1;
        vblk[3][1] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", int'(player_x), 8);
        chk("reset_y", int'(player_y), 8);
        chk("reset_heading", int'(heading), 0);
        chk("reset_pulses", int'({step_pulse, bump}), 0);
        rst_n = 1;
        run(20, 4'b0000, 0, 1);
        force_chk = 1;
        run(4, 4'b0001, 0, 1);
        run(3, 4'b0000, 0, 1);
        run(1, 4'b1000, 0, 1);
        run(30, 4'b0000, 0, 1);
        force_chk = 1;
        step_cycle(4'b0000, 0, 1, 1);
        run(1, 4'b0001, 0, 1);
        run(9, 4'b0000, 0, 1);
        run(1, 4'b0010, 0, 1);
        run(10, 4'b0000, 0, 1);
        force_chk = 1;
        step_cycle(4'b0000, 0, 1, 1);
        run(30, 4'b0001, 0, 1);
        force_chk = 1;
        step_cycle(4'b0000, 0, 1, 1);
        run(12, 4'b0001, 1, 1);
        force_chk = 1;
        run(10, 4'b0000, 1, 0);
        force_chk = 1;
        run(3, 4'b0000, 0, 1);
        step_cycle(4'b0000, 0, 1, 1);
        force_chk = 1;
        run(1, 4'b0000, 0, 1);
        chk("bump_seen", int'(n_bump > 0), 1);
        bst = 0;
        for (int i = 0; i < 3000; i++) begin
            bt = $urandom_range(5) == 0 ? 4'($urandom_range(15)) : 4'b0000;
            if ($urandom_range(49) == 0) bst = ~bst;
            step_cycle(bt, bst, $urandom_range(19) != 0, $urandom_range(499) == 0);
        end
        force_chk = 1;
        run(3, 4'b0000, 0, 0);
        force_chk = 1;
        run(1, 4'b0000, 0, 0);
        chk("queue_empty", q.size(), 0);
        chk("steps_seen", int'(n_step > 20), 1);
        step_cycle(4'b0000, 0, 1, 1);
        run(1, 4'b0001, 0, 1);
        run(5, 4'b0000, 0, 1);
        @(posedge clk);
        #1;
        chk("pre_async_x", int'(player_x), m_x);
        chk("midtile", int'(player_x) % 4 != 0, 1);
        #3;
        rst_n = 0;
        #1;
        chk("async_x", int'(player_x), 8);
        chk("async_y", int'(player_y), 8);
        chk("async_heading", int'(heading), 0);
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        en = 0;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        run(4, 4'b0000, 0, 1);
        force_chk = 1;
        run(1, 4'b0000, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
